// File: rtl/psr_unit.sv
// psr_unit: ARMv7 CPSR, the seven banked SPSRs and the exception-entry sequencer.
// Exception entry runs IDLE -> SAVE -> LINK: the mode switches on SAVE, and the
// banked LR write and PC redirect strobe during LINK.
// Optional build macro: PSR_PRIV_CHECK_EN. When defined, a usr-mode MSR to the
// CPSR may only change the flags byte.
module psr_unit #(
  parameter logic [31:0] VECTOR_BASE = 32'h0000_0000,
  parameter logic [4:0]  RESET_MODE  = 5'b10011
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic [3:0]  NZCV_In,
  input  logic        Write_NZCV,
  input  logic [31:0] PSR_Data,
  input  logic [3:0]  PSR_Mask,
  input  logic        Write_CPSR,
  input  logic        Write_SPSR,
  input  logic [5:0]  Exc_Req,
  input  logic        Exc_Return,
  input  logic [31:0] PC_Cur,
  output logic [31:0] CPSR,
  output logic [31:0] SPSR,
  output logic [4:0]  M,
  output logic [31:0] LR_Data,
  output logic        Write_LR,
  output logic [31:0] PC_New,
  output logic        Write_PC,
  output logic        Exc_Busy,
  output logic        err
);

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;

  // Bit positions inside Exc_Req = {fiq, irq, dabt, pabt, svc, und}
  localparam int EXC_UND  = 0;
  localparam int EXC_PABT = 2;
  localparam int EXC_DABT = 3;
  localparam int EXC_IRQ  = 4;
  localparam int EXC_FIQ  = 5;

  typedef enum logic [1:0] {IDLE, SAVE, LINK} state_t;

  state_t      state;
  logic [31:0] spsr_bank [7];
  logic [2:0]  tgt_idx;
  logic [4:0]  tgt_mode;
  logic        tgt_fiq;
  logic [7:0]  vec_off;
  logic [31:0] lr_hold;

  // Modes that own an SPSR; usr, sys and reserved encodings have none.
  function automatic logic is_banked(input logic [4:0] mode);
    case (mode)
      5'b10001, 5'b10010, 5'b10011, 5'b10110,
      5'b10111, 5'b11010, 5'b11011: is_banked = 1'b1;
      default:                      is_banked = 1'b0;
    endcase
  endfunction

  // SPSR slot: fiq, irq, svc, mon, abt, hyp, und.
  function automatic logic [2:0] bank_idx(input logic [4:0] mode);
    case (mode)
      5'b10001: bank_idx = 3'd0;
      5'b10010: bank_idx = 3'd1;
      5'b10011: bank_idx = 3'd2;
      5'b10110: bank_idx = 3'd3;
      5'b10111: bank_idx = 3'd4;
      5'b11010: bank_idx = 3'd5;
      5'b11011: bank_idx = 3'd6;
      default:  bank_idx = 3'd0;
    endcase
  endfunction

  function automatic logic legal_mode(input logic [4:0] mode);
    case (mode)
      5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10110,
      5'b10111, 5'b11010, 5'b11011, 5'b11111: legal_mode = 1'b1;
      default:                                legal_mode = 1'b0;
    endcase
  endfunction

  logic       cur_banked;
  logic [2:0] cur_idx;

  assign cur_banked = is_banked(CPSR[4:0]);
  assign cur_idx    = bank_idx(CPSR[4:0]);
  assign SPSR       = cur_banked ? spsr_bank[cur_idx] : 32'h0;
  assign M          = CPSR[4:0];

  logic [5:0] exc_pend;
  logic       exc_take;
  logic [4:0] exc_mode;
  logic [7:0] exc_vec;
  logic [3:0] exc_lr_off;
  logic       exc_fiq;

  // Pick the winning exception after I/F masking: dabt > fiq > irq > pabt > und > svc.
  always_comb begin
    // NOTE: every output gets a default first so no path can leave it unassigned (no latch).
    exc_pend   = Exc_Req & ~{CPSR[6], CPSR[7], 4'b0000};
    exc_take   = |exc_pend;
    exc_mode   = MODE_SVC;
    exc_vec    = 8'h08;
    exc_lr_off = 4'd4;
    exc_fiq    = 1'b0;
    if (exc_pend[EXC_DABT]) begin
      exc_mode   = MODE_ABT;
      exc_vec    = 8'h10;
      exc_lr_off = 4'd8;
    end else if (exc_pend[EXC_FIQ]) begin
      exc_mode = MODE_FIQ;
      exc_vec  = 8'h1C;
      exc_fiq  = 1'b1;
    end else if (exc_pend[EXC_IRQ]) begin
      exc_mode = MODE_IRQ;
      exc_vec  = 8'h18;
    end else if (exc_pend[EXC_PABT]) begin
      exc_mode = MODE_ABT;
      exc_vec  = 8'h0C;
    end else if (exc_pend[EXC_UND]) begin
      exc_mode = MODE_UND;
      exc_vec  = 8'h04;
    end
  end

  logic [31:0] cpsr_wr;
  logic [31:0] spsr_wr;
  logic [3:0]  cmask;
  logic        wr_err;

  // Merge MSR / flag writes into candidate CPSR and SPSR values and flag illegal ones.
  always_comb begin
    cpsr_wr = CPSR;
    spsr_wr = SPSR;
    cmask   = PSR_Mask;
    wr_err  = 1'b0;
    if (Write_CPSR) begin
`ifdef PSR_PRIV_CHECK_EN
      if (CPSR[4:0] == MODE_USR && |cmask[2:0]) begin
        cmask[2:0] = 3'b000;
        wr_err     = 1'b1;
      end
`endif
      if (cmask[0] && !legal_mode(PSR_Data[4:0])) begin
        cmask[0] = 1'b0;
        wr_err   = 1'b1;
      end
      for (int b = 0; b < 4; b++) begin
        if (cmask[b]) cpsr_wr[8*b +: 8] = PSR_Data[8*b +: 8];
      end
    end
    // An MSR that writes the flags byte overrides the ALU flags.
    if (Write_NZCV && !(Write_CPSR && cmask[3])) cpsr_wr[31:28] = NZCV_In;
    if (Write_SPSR) begin
      if (cur_banked) begin
        for (int b = 0; b < 4; b++) begin
          if (PSR_Mask[b]) spsr_wr[8*b +: 8] = PSR_Data[8*b +: 8];
        end
      end else begin
        wr_err = 1'b1;
      end
    end
  end

  // Register state: entry sequencer, CPSR/SPSR updates and registered strobes.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (Rst) begin
      state    <= IDLE;
      CPSR     <= {24'h0, 1'b1, 1'b1, 1'b0, RESET_MODE};
      // NOTE: the SPSR bank is small and its reset value is architecturally visible, so it is reset explicitly.
      for (int i = 0; i < 7; i++) spsr_bank[i] <= 32'h0;
      tgt_idx  <= 3'd0;
      tgt_mode <= RESET_MODE;
      tgt_fiq  <= 1'b0;
      vec_off  <= 8'h00;
      lr_hold  <= 32'h0;
      LR_Data  <= 32'h0;
      PC_New   <= 32'h0;
      Write_LR <= 1'b0;
      Write_PC <= 1'b0;
      Exc_Busy <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (exc_take) begin
            tgt_mode <= exc_mode;
            tgt_idx  <= bank_idx(exc_mode);
            tgt_fiq  <= exc_fiq;
            vec_off  <= exc_vec;
            lr_hold  <= PC_Cur + {28'h0, exc_lr_off};
            Exc_Busy <= 1'b1;
            state    <= SAVE;
          end else if (Exc_Return) begin
            if (cur_banked) CPSR <= spsr_bank[cur_idx];
            else            err  <= 1'b1;
          end else begin
            CPSR <= cpsr_wr;
            if (Write_SPSR && cur_banked) spsr_bank[cur_idx] <= spsr_wr;
            err <= wr_err;
          end
        end
        SAVE: begin
          spsr_bank[tgt_idx] <= CPSR;
          CPSR[4:0] <= tgt_mode;
          CPSR[7]   <= 1'b1;
          CPSR[5]   <= 1'b0;
          if (tgt_fiq) CPSR[6] <= 1'b1;
          LR_Data  <= lr_hold;
          PC_New   <= VECTOR_BASE + {24'h0, vec_off};
          Write_LR <= 1'b1;
          Write_PC <= 1'b1;
          state    <= LINK;
        end
        LINK: begin
          Write_LR <= 1'b0;
          Write_PC <= 1'b0;
          Exc_Busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psr_unit.sv
// tb_psr_unit: directed vector table, a hand-written priority sequence and a
// randomized run, all compared against a mode-indexed behavioural model.
module tb_psr_unit;

  localparam logic [31:0] VB = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  nzcv_in;
  logic        write_nzcv;
  logic [31:0] psr_data;
  logic [3:0]  psr_mask;
  logic        write_cpsr;
  logic        write_spsr;
  logic [5:0]  exc_req;
  logic        exc_return;
  logic [31:0] pc_cur;
  logic [31:0] cpsr;
  logic [31:0] spsr;
  logic [4:0]  m;
  logic [31:0] lr_data;
  logic        write_lr;
  logic [31:0] pc_new;
  logic        write_pc;
  logic        exc_busy;
  logic        err;

  psr_unit #(.VECTOR_BASE(VB), .RESET_MODE(5'b10011)) dut (
    .clk(clk), .Rst(rst), .NZCV_In(nzcv_in), .Write_NZCV(write_nzcv),
    .PSR_Data(psr_data), .PSR_Mask(psr_mask), .Write_CPSR(write_cpsr),
    .Write_SPSR(write_spsr), .Exc_Req(exc_req), .Exc_Return(exc_return),
    .PC_Cur(pc_cur), .CPSR(cpsr), .SPSR(spsr), .M(m), .LR_Data(lr_data),
    .Write_LR(write_lr), .PC_New(pc_new), .Write_PC(write_pc),
    .Exc_Busy(exc_busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [5:0]  req;
    logic        ret;
    logic        wcpsr;
    logic        wspsr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        wnzcv;
    logic [3:0]  nzcv;
    logic [31:0] pc;
  } in_t;

  typedef struct {
    in_t         in;
    logic [31:0] cpsr;
    logic [31:0] spsr;
    logic        stb;
    logic [31:0] lr;
    logic [31:0] pcn;
    logic        busy;
    logic        err;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Exception tables indexed by Exc_Req bit: und, svc, pabt, dabt, irq, fiq.
  int         prio  [6] = '{3, 5, 4, 2, 0, 1};
  logic [4:0] tmode [6] = '{5'b11011, 5'b10011, 5'b10111, 5'b10111, 5'b10010, 5'b10001};
  logic [7:0] voff  [6] = '{8'h04, 8'h08, 8'h0C, 8'h10, 8'h18, 8'h1C};
  logic [3:0] lroff [6] = '{4'd4, 4'd4, 4'd4, 4'd8, 4'd4, 4'd4};
  logic [4:0] legal_list [9] = '{5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10110,
                                 5'b10111, 5'b11010, 5'b11011, 5'b11111};

  // Behavioural model: SPSRs kept per mode number, entry tracked as a phase count.
  logic [31:0] m_cpsr;
  logic [31:0] m_spsr [32];
  int          m_phase;
  logic [4:0]  m_tgt;
  logic [7:0]  m_vec;
  logic [31:0] m_lr;
  logic        m_stb;
  logic        m_busy;
  logic        m_err;
  logic [31:0] m_lr_out;
  logic [31:0] m_pc_out;

  function automatic logic banked(input logic [4:0] md);
    return md inside {5'b10001, 5'b10010, 5'b10011, 5'b10110, 5'b10111, 5'b11010, 5'b11011};
  endfunction

  function automatic logic legal(input logic [4:0] md);
    return md inside {5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10110,
                      5'b10111, 5'b11010, 5'b11011, 5'b11111};
  endfunction

  task automatic model_edge(input in_t v);
    logic [5:0] pend;
    logic [3:0] mk;
    logic [4:0] md;
    int         b;
    bit         taken;
    if (v.rst) begin
      m_cpsr = 32'h0000_00D3;
      foreach (m_spsr[i]) m_spsr[i] = 32'h0;
      m_phase = 0; m_stb = 0; m_busy = 0; m_err = 0;
      m_lr_out = 32'h0; m_pc_out = 32'h0;
      return;
    end
    m_err = 0;
    if (m_phase == 2) begin
      m_stb = 0; m_busy = 0; m_phase = 0;
    end else if (m_phase == 1) begin
      m_spsr[m_tgt] = m_cpsr;
      m_cpsr[4:0] = m_tgt;
      m_cpsr[7] = 1'b1;
      m_cpsr[5] = 1'b0;
      if (m_tgt == 5'b10001) m_cpsr[6] = 1'b1;
      m_stb = 1; m_lr_out = m_lr; m_pc_out = VB + {24'h0, m_vec};
      m_phase = 2;
    end else begin
      pend = v.req;
      if (m_cpsr[7]) pend[4] = 1'b0;
      if (m_cpsr[6]) pend[5] = 1'b0;
      taken = 0; b = 0;
      for (int k = 0; k < 6; k++) begin
        if (!taken && pend[prio[k]]) begin taken = 1; b = prio[k]; end
      end
      md = m_cpsr[4:0];
      if (taken) begin
        m_tgt = tmode[b]; m_vec = voff[b]; m_lr = v.pc + {28'h0, lroff[b]};
        m_busy = 1; m_phase = 1;
      end else if (v.ret) begin
        if (banked(md)) m_cpsr = m_spsr[md];
        else m_err = 1;
      end else begin
        if (v.wcpsr) begin
          mk = v.mask;
`ifdef PSR_PRIV_CHECK_EN
          if (md == 5'b10000 && mk[2:0] != 3'b000) begin mk[2:0] = 3'b000; m_err = 1; end
`endif
          if (mk[0] && !legal(v.data[4:0])) begin mk[0] = 1'b0; m_err = 1; end
          for (int j = 0; j < 4; j++) if (mk[j]) m_cpsr[8*j +: 8] = v.data[8*j +: 8];
        end
        if (v.wnzcv && !(v.wcpsr && v.mask[3])) m_cpsr[31:28] = v.nzcv;
        if (v.wspsr) begin
          if (banked(md)) begin
            for (int j = 0; j < 4; j++) if (v.mask[j]) m_spsr[md][8*j +: 8] = v.data[8*j +: 8];
          end else begin
            m_err = 1;
          end
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] exp_spsr;
    exp_spsr = banked(m_cpsr[4:0]) ? m_spsr[m_cpsr[4:0]] : 32'h0;
    check({tag, " cpsr"}, cpsr, m_cpsr);
    check({tag, " m"}, {27'h0, m}, {27'h0, m_cpsr[4:0]});
    check({tag, " spsr"}, spsr, exp_spsr);
    check({tag, " write_lr"}, {31'h0, write_lr}, {31'h0, m_stb});
    check({tag, " write_pc"}, {31'h0, write_pc}, {31'h0, m_stb});
    check({tag, " lr_data"}, lr_data, m_lr_out);
    check({tag, " pc_new"}, pc_new, m_pc_out);
    check({tag, " busy"}, {31'h0, exc_busy}, {31'h0, m_busy});
    check({tag, " err"}, {31'h0, err}, {31'h0, m_err});
  endtask

  task automatic step(input in_t v, input string tag);
    rst = v.rst; exc_req = v.req; exc_return = v.ret;
    write_cpsr = v.wcpsr; write_spsr = v.wspsr; psr_mask = v.mask;
    psr_data = v.data; write_nzcv = v.wnzcv; nzcv_in = v.nzcv; pc_cur = v.pc;
    @(posedge clk);
    model_edge(v);
    #1;
    check_model(tag);
  endtask

  function automatic in_t mk_in(input logic r, input logic [5:0] req, input logic ret,
                                input logic wc, input logic ws, input logic [3:0] mask,
                                input logic [31:0] data, input logic wn, input logic [3:0] nz,
                                input logic [31:0] pc);
    in_t v;
    v.rst = r; v.req = req; v.ret = ret; v.wcpsr = wc; v.wspsr = ws;
    v.mask = mask; v.data = data; v.wnzcv = wn; v.nzcv = nz; v.pc = pc;
    return v;
  endfunction

  function automatic vec_t mk(input in_t v, input logic [31:0] c, input logic [31:0] s,
                              input logic stb, input logic [31:0] lr, input logic [31:0] pcn,
                              input logic busy, input logic e);
    vec_t t;
    t.in = v; t.cpsr = c; t.spsr = s; t.stb = stb; t.lr = lr; t.pcn = pcn;
    t.busy = busy; t.err = e;
    return t;
  endfunction

  function automatic in_t rand_in();
    in_t v;
    v.rst   = ($urandom_range(0, 199) == 0);
    v.req   = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'h00;
    v.ret   = ($urandom_range(0, 9) == 0);
    v.wcpsr = !v.ret && ($urandom_range(0, 4) == 0);
    v.wspsr = !v.ret && ($urandom_range(0, 4) == 0);
    v.wnzcv = !v.ret && ($urandom_range(0, 3) == 0);
    v.mask  = 4'($urandom);
    v.data  = $urandom;
    if (v.wspsr || $urandom_range(0, 3) != 0) v.data[4:0] = legal_list[$urandom_range(0, 8)];
    v.nzcv  = 4'($urandom);
    v.pc    = $urandom;
    return v;
  endfunction

  vec_t vecs[$];
  in_t  idle;

  initial begin
    rst = 1'b1; exc_req = '0; exc_return = 1'b0; write_cpsr = 1'b0; write_spsr = 1'b0;
    psr_mask = '0; psr_data = '0; write_nzcv = 1'b0; nzcv_in = '0; pc_cur = '0;
    idle = mk_in(0, 6'h00, 0, 0, 0, 4'h0, 32'h0, 0, 4'h0, 32'h0);

    // Directed sequence; expected outputs after each edge.
    vecs.push_back(mk(mk_in(1, 6'h00, 0, 0, 0, 4'h0, 32'h0, 0, 4'h0, 32'h0),        32'h0000_00D3, 32'h0, 0, 32'h0,    32'h00, 0, 0));
    vecs.push_back(mk(mk_in(0, 6'h00, 0, 1, 0, 4'h1, 32'h10, 0, 4'h0, 32'h0),       32'h0000_0010, 32'h0, 0, 32'h0,    32'h00, 0, 0));
    vecs.push_back(mk(mk_in(0, 6'h10, 0, 0, 0, 4'h0, 32'h0, 0, 4'h0, 32'h1000),     32'h0000_0010, 32'h0, 0, 32'h0,    32'h00, 1, 0));
    vecs.push_back(mk(idle,                                                         32'h0000_0092, 32'h10, 1, 32'h1004, 32'h18, 1, 0));
    vecs.push_back(mk(idle,                                                         32'h0000_0092, 32'h10, 0, 32'h1004, 32'h18, 0, 0));
    vecs.push_back(mk(mk_in(0, 6'h10, 0, 0, 0, 4'h0, 32'h0, 0, 4'h0, 32'h5000),     32'h0000_0092, 32'h10, 0, 32'h1004, 32'h18, 0, 0));
    vecs.push_back(mk(mk_in(0, 6'h00, 1, 0, 0, 4'h0, 32'h0, 0, 4'h0, 32'h0),        32'h0000_0010, 32'h0, 0, 32'h1004, 32'h18, 0, 0));
    vecs.push_back(mk(mk_in(0, 6'h00, 1, 0, 0, 4'h0, 32'h0, 0, 4'h0, 32'h0),        32'h0000_0010, 32'h0, 0, 32'h1004, 32'h18, 0, 1));
    vecs.push_back(mk(mk_in(0, 6'h3F, 0, 0, 0, 4'h0, 32'h0, 0, 4'h0, 32'h2000),     32'h0000_0010, 32'h0, 0, 32'h1004, 32'h18, 1, 0));
    vecs.push_back(mk(idle,                                                         32'h0000_0097, 32'h10, 1, 32'h2008, 32'h10, 1, 0));
    vecs.push_back(mk(idle,                                                         32'h0000_0097, 32'h10, 0, 32'h2008, 32'h10, 0, 0));
    vecs.push_back(mk(mk_in(0, 6'h00, 0, 1, 0, 4'h1, 32'h14, 0, 4'h0, 32'h0),       32'h0000_0097, 32'h10, 0, 32'h2008, 32'h10, 0, 1));
    vecs.push_back(mk(mk_in(0, 6'h00, 0, 1, 0, 4'h1, 32'h1F, 0, 4'h0, 32'h0),       32'h0000_001F, 32'h0, 0, 32'h2008, 32'h10, 0, 0));
    vecs.push_back(mk(mk_in(0, 6'h00, 0, 0, 1, 4'hF, 32'h1234_5678, 0, 4'h0, 32'h0), 32'h0000_001F, 32'h0, 0, 32'h2008, 32'h10, 0, 1));
    vecs.push_back(mk(mk_in(0, 6'h00, 0, 0, 0, 4'h0, 32'h0, 1, 4'hA, 32'h0),        32'hA000_001F, 32'h0, 0, 32'h2008, 32'h10, 0, 0));
    vecs.push_back(mk(mk_in(0, 6'h00, 0, 1, 0, 4'h8, 32'h5000_0000, 1, 4'hF, 32'h0), 32'h5000_001F, 32'h0, 0, 32'h2008, 32'h10, 0, 0));
    vecs.push_back(mk(mk_in(0, 6'h02, 0, 0, 0, 4'h0, 32'h0, 0, 4'h0, 32'hFFFF_FFFC), 32'h5000_001F, 32'h0, 0, 32'h2008, 32'h10, 1, 0));
    vecs.push_back(mk(idle,                                                         32'h5000_0093, 32'h5000_001F, 1, 32'h0, 32'h08, 1, 0));
    vecs.push_back(mk(mk_in(0, 6'h01, 0, 0, 0, 4'h0, 32'h0, 0, 4'h0, 32'h4000),     32'h5000_0093, 32'h5000_001F, 0, 32'h0, 32'h08, 0, 0));
    vecs.push_back(mk(mk_in(0, 6'h00, 0, 0, 1, 4'h1, 32'hD1, 0, 4'h0, 32'h0),       32'h5000_0093, 32'h5000_00D1, 0, 32'h0, 32'h08, 0, 0));
    vecs.push_back(mk(mk_in(0, 6'h20, 0, 0, 0, 4'h0, 32'h0, 0, 4'h0, 32'h3000),     32'h5000_0093, 32'h5000_00D1, 0, 32'h0, 32'h08, 1, 0));
    vecs.push_back(mk(idle,                                                         32'h5000_00D1, 32'h5000_0093, 1, 32'h3004, 32'h1C, 1, 0));
    vecs.push_back(mk(idle,                                                         32'h5000_00D1, 32'h5000_0093, 0, 32'h3004, 32'h1C, 0, 0));
    vecs.push_back(mk(mk_in(0, 6'h01, 0, 0, 0, 4'h0, 32'h0, 0, 4'h0, 32'h4000),     32'h5000_00D1, 32'h5000_0093, 0, 32'h3004, 32'h1C, 1, 0));
    vecs.push_back(mk(mk_in(1, 6'h00, 0, 0, 0, 4'h0, 32'h0, 0, 4'h0, 32'h0),        32'h0000_00D3, 32'h0, 0, 32'h0,    32'h00, 0, 0));
    vecs.push_back(mk(idle,                                                         32'h0000_00D3, 32'h0, 0, 32'h0,    32'h00, 0, 0));

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(vecs[i].in, tag);
      check({tag, " tbl cpsr"}, cpsr, vecs[i].cpsr);
      check({tag, " tbl spsr"}, spsr, vecs[i].spsr);
      check({tag, " tbl write_lr"}, {31'h0, write_lr}, {31'h0, vecs[i].stb});
      check({tag, " tbl write_pc"}, {31'h0, write_pc}, {31'h0, vecs[i].stb});
      check({tag, " tbl lr_data"}, lr_data, vecs[i].lr);
      check({tag, " tbl pc_new"}, pc_new, vecs[i].pcn);
      check({tag, " tbl busy"}, {31'h0, exc_busy}, {31'h0, vecs[i].busy});
      check({tag, " tbl err"}, {31'h0, err}, {31'h0, vecs[i].err});
    end

    // Exception accepted together with MSR, flag write and return: the exception wins.
    step(mk_in(0, 6'h01, 1, 1, 1, 4'hF, 32'h0000_001F, 1, 4'hF, 32'h8000), "race0");
    check("race0 cpsr kept", cpsr, 32'h0000_00D3);
    check("race0 spsr kept", spsr, 32'h0);
    step(idle, "race1");
    check("race1 und mode", {27'h0, m}, {27'h0, 5'b11011});
    check("race1 und spsr", spsr, 32'h0000_00D3);
    check("race1 lr", lr_data, 32'h8004);
    check("race1 vector", pc_new, 32'h04);
    step(idle, "race2");
    check("race2 strobe low", {31'h0, write_lr}, 32'h0);

    // Randomized run against the model.
    step(mk_in(1, 6'h00, 0, 0, 0, 4'h0, 32'h0, 0, 4'h0, 32'h0), "rnd_rst");
    for (int n = 0; n < 3000; n++) begin
      step(rand_in(), $sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
